// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared ALU operation codes and HI/LO unit state encoding.
// Also holds helpers that classify a 6-bit ALUOperation code for the HI/LO unit.
package muldiv_hilo_unit_pkg;

  localparam logic [5:0] ALU_SLL  = 6'b000000;
  localparam logic [5:0] ALU_SRL  = 6'b000010;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_SLT  = 6'b101010;

  localparam logic [5:0] MD_MFHI  = 6'b010000;
  localparam logic [5:0] MD_MTHI  = 6'b010001;
  localparam logic [5:0] MD_MFLO  = 6'b010010;
  localparam logic [5:0] MD_MTLO  = 6'b010011;
  localparam logic [5:0] MD_MULT  = 6'b011000;
  localparam logic [5:0] MD_MULTU = 6'b011001;
  localparam logic [5:0] MD_DIV   = 6'b011010;
  localparam logic [5:0] MD_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  function automatic logic op_is_iter(input logic [5:0] op);
    return op[5:2] == 4'b0110;
  endfunction

  // Bit 0 clear selects the signed variant of mult/div.
  function automatic logic op_is_signed(input logic [5:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(input logic [5:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_known(input logic [5:0] op);
    return op[5:3] == 3'b010 || op[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_hilo_unit_core.sv
// Iterative multiply/divide datapath: abs conversion on start, one radix-2
// shift-add or restoring step per step strobe, sign-corrected result on fix.
module muldiv_core
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_fix,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_wr,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0]   r_hi, r_lo, r_b, r_raw_a;
  logic               r_div, r_dz, r_sa, r_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_sum, w_shift, w_trial;
  logic [2*WIDTH-1:0] w_prod;

  assign w_abs_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_abs_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_b};
  end

  // Multiply keeps the multiplier in r_lo and shifts the product in from the
  // top; divide keeps the dividend in r_lo and shifts quotient bits in below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_raw_a <= '0;
      r_div   <= 1'b0;
      r_dz    <= 1'b0;
      r_sa    <= 1'b0;
      r_neg   <= 1'b0;
    end else if (i_start) begin
      r_hi    <= '0;
      r_lo    <= i_is_div ? w_abs_a : w_abs_b;
      r_b     <= i_is_div ? w_abs_b : w_abs_a;
      r_raw_a <= i_a;
      r_div   <= i_is_div;
      r_dz    <= i_is_div && (i_b == '0);
      r_sa    <= i_signed && i_a[WIDTH-1];
      r_neg   <= i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (i_step) begin
      if (r_div) begin
        if (!w_trial[WIDTH]) begin
          r_hi <= w_trial[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign o_wr   = i_fix;

  always_comb begin
    o_hi = w_prod[2*WIDTH-1:WIDTH];
    o_lo = w_prod[WIDTH-1:0];
    if (r_div) begin
      if (r_dz) begin
        o_hi = r_raw_a;
        o_lo = '1;
      end else begin
        o_lo = r_neg ? -r_lo : r_lo;
        o_hi = r_sa ? -r_hi : r_hi;
      end
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage multiply/divide unit: FSM, iteration counter, hazard stall and
// architectural HI/LO registers around the iterative muldiv_core datapath.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  md_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic [5:0]       w_op;
  logic             w_idle, w_accept, w_mthi, w_mtlo, w_step, w_fix;
  logic             w_core_wr;
  logic [WIDTH-1:0] w_core_hi, w_core_lo;

  assign w_op     = 6'(op);
  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && op_valid && !flush && op_is_iter(w_op);
  assign w_mthi   = w_idle && op_valid && !flush && (w_op == MD_MTHI);
  assign w_mtlo   = w_idle && op_valid && !flush && (w_op == MD_MTLO);
  assign w_step   = (r_state == ST_RUN) && !flush;
  assign w_fix    = (r_state == ST_FIX) && !flush;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept),
    .i_step   (w_step),
    .i_fix    (w_fix),
    .i_is_div (op_is_div(w_op)),
    .i_signed (op_is_signed(w_op)),
    .i_a      (src_a),
    .i_b      (src_b),
    .o_wr     (w_core_wr),
    .o_hi     (w_core_hi),
    .o_lo     (w_core_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_done  <= !flush;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_core_wr) begin
      r_hi <= w_core_hi;
      r_lo <= w_core_lo;
    end else begin
      if (w_mthi) r_hi <= src_a;
      if (w_mtlo) r_lo <= src_a;
    end
  end

  // The done cycle is already IDLE, so mf reads there see the fresh result.
  always_comb begin
    mf_data = '0;
    if (op_valid && w_idle) begin
      if (w_op == MD_MFHI)      mf_data = r_hi;
      else if (w_op == MD_MFLO) mf_data = r_lo;
    end
  end

  assign busy  = !w_idle;
  assign done  = r_done;
  assign stall = op_valid && !w_idle && op_is_known(w_op);
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed self-checking bench for muldiv_hilo_unit at WIDTH=32.
module tb_muldiv_hilo_unit;

  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [5:0]  op = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush = 1'b0;
  logic        busy, done, stall;
  logic [31:0] mf_data, hi, lo;

  int n_pass = 0;
  int n_total = 0;

  muldiv_hilo_unit #(.WIDTH(32), .OP_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .stall    (stall),
    .mf_data  (mf_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  // Issue one iterative op, then wait (bounded) for done; latency counts edges after accept.
  task automatic issue_and_wait(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output int busy_n);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = '0;
    busy_n = busy ? 1 : 0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else n_pass++;
    n_total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu;
    int lat, bn;
    issue_and_wait(OP_MULTU, 32'hFFFFFFFF, 32'd2, lat, bn);
    n_total++; if (lat !== 33) $display("FAIL multu_latency got %0d want 33", lat); else n_pass++;
    n_total++; if (bn !== 33) $display("FAIL multu_busy_cycles got %0d want 33", bn); else n_pass++;
    n_total++; if (hi !== 32'h00000001) $display("FAIL multu_hi got %h want 00000001", hi); else n_pass++;
    n_total++; if (lo !== 32'hFFFFFFFE) $display("FAIL multu_lo got %h want fffffffe", lo); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL multu_busy_at_done got %b want 0", busy); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (done !== 1'b0) $display("FAIL multu_done_single got %b want 0", done); else n_pass++;
  endtask

  task automatic test_mult_signed;
    int lat, bn;
    issue_and_wait(OP_MULT, 32'hFFFFFFFD, 32'd5, lat, bn);
    n_total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want ffffffff", hi); else n_pass++;
    n_total++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo got %h want fffffff1", lo); else n_pass++;
    issue_and_wait(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFF9, lat, bn);
    n_total++; if (hi !== 32'h0) $display("FAIL mult_negneg_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'd14) $display("FAIL mult_negneg_lo got %h want e", lo); else n_pass++;
  endtask

  task automatic test_divide;
    int lat, bn;
    issue_and_wait(OP_DIVU, 32'd100, 32'd7, lat, bn);
    n_total++; if (lo !== 32'd14) $display("FAIL divu_lo got %h want e", lo); else n_pass++;
    n_total++; if (hi !== 32'd2) $display("FAIL divu_hi got %h want 2", hi); else n_pass++;
    n_total++; if (lat !== 33) $display("FAIL divu_latency got %0d want 33", lat); else n_pass++;
    issue_and_wait(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bn);
    n_total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_neg_lo got %h want fffffffd", lo); else n_pass++;
    n_total++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_neg_hi got %h want ffffffff", hi); else n_pass++;
    issue_and_wait(OP_DIV, 32'd7, 32'hFFFFFFFE, lat, bn);
    n_total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_negdiv_lo got %h want fffffffd", lo); else n_pass++;
    n_total++; if (hi !== 32'd1) $display("FAIL div_negdiv_hi got %h want 1", hi); else n_pass++;
    issue_and_wait(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bn);
    n_total++; if (lo !== 32'h80000000) $display("FAIL div_ovf_lo got %h want 80000000", lo); else n_pass++;
    n_total++; if (hi !== 32'h0) $display("FAIL div_ovf_hi got %h want 0", hi); else n_pass++;
  endtask

  task automatic test_div_by_zero;
    int lat, bn;
    issue_and_wait(OP_DIVU, 32'h00001234, 32'd0, lat, bn);
    n_total++; if (lat !== 33) $display("FAIL divz_latency got %0d want 33", lat); else n_pass++;
    n_total++; if (lo !== 32'hFFFFFFFF) $display("FAIL divz_lo got %h want ffffffff", lo); else n_pass++;
    n_total++; if (hi !== 32'h00001234) $display("FAIL divz_hi got %h want 00001234", hi); else n_pass++;
    issue_and_wait(OP_DIV, 32'hFFFFFFFB, 32'd0, lat, bn);
    n_total++; if (lo !== 32'hFFFFFFFF) $display("FAIL divz_signed_lo got %h want ffffffff", lo); else n_pass++;
    n_total++; if (hi !== 32'hFFFFFFFB) $display("FAIL divz_signed_hi got %h want fffffffb", hi); else n_pass++;
  endtask

  task automatic test_mf_stall;
    int n;
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op = '0;
    @(posedge clk); #1;
    op_valid = 1'b1; op = OP_MFLO;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    n_total++; if (n !== 32) $display("FAIL mf_stall_cycles got %0d want 32", n); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL mf_done_cycle got %b want 1", done); else n_pass++;
    n_total++; if (mf_data !== 32'd14) $display("FAIL mf_data_new_lo got %h want e", mf_data); else n_pass++;
    op = OP_MFHI;
    #1;
    n_total++; if (mf_data !== 32'd2) $display("FAIL mf_data_hi got %h want 2", mf_data); else n_pass++;
    op_valid = 1'b0; op = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_mt;
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'h0000AAAA;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL mthi_stall got %b want 0", stall); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (hi !== 32'h0000AAAA) $display("FAIL mthi_hi got %h want 0000aaaa", hi); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", busy); else n_pass++;
    op = OP_MTLO; src_a = 32'h00005555;
    @(posedge clk); #1;
    n_total++; if (lo !== 32'h00005555) $display("FAIL mtlo_lo got %h want 00005555", lo); else n_pass++;
    n_total++; if (hi !== 32'h0000AAAA) $display("FAIL mtlo_hi_kept got %h want 0000aaaa", hi); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mt_done got %b want 0", done); else n_pass++;
    op = OP_MFHI;
    #1;
    n_total++; if (mf_data !== 32'h0000AAAA) $display("FAIL mfhi_data got %h want 0000aaaa", mf_data); else n_pass++;
    op_valid = 1'b0; op = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    int dn;
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0; op = '0;
    repeat (9) begin @(posedge clk); #1; end
    op_valid = 1'b1; op = OP_ADD;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL unknown_op_stall got %b want 0", stall); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL flush_pre_busy got %b want 1", busy); else n_pass++;
    op_valid = 1'b0; op = '0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else n_pass++;
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dn++; end
    n_total++; if (dn !== 0) $display("FAIL flush_no_done got %0d pulses want 0", dn); else n_pass++;
    n_total++; if (hi !== 32'h0000AAAA) $display("FAIL flush_hi got %h want 0000aaaa", hi); else n_pass++;
    n_total++; if (lo !== 32'h00005555) $display("FAIL flush_lo got %h want 00005555", lo); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int dn;
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op = '0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy); else n_pass++;
    n_total++; if (hi !== 32'h0) $display("FAIL rstmid_hi got %h want 0", hi); else n_pass++;
    n_total++; if (lo !== 32'h0) $display("FAIL rstmid_lo got %h want 0", lo); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin @(posedge clk); #1; if (done) dn++; end
    n_total++; if (dn !== 0) $display("FAIL rstmid_no_done got %0d pulses want 0", dn); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    issue_and_wait(OP_MULTU, 32'd6, 32'd7, lat, bn);
    n_total++; if (lo !== 32'd42) $display("FAIL b2b_first_lo got %h want 2a", lo); else n_pass++;
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    #1;
    n_total++; if (stall !== 1'b0) $display("FAIL b2b_stall_in_done got %b want 0", stall); else n_pass++;
    @(posedge clk); #1;
    op_valid = 1'b0; op = '0;
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_after got %b want 1", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL b2b_done_after got %b want 0", done); else n_pass++;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_total++; if (lat !== 33) $display("FAIL b2b_latency got %0d want 33", lat); else n_pass++;
    n_total++; if (lo !== 32'd14) $display("FAIL b2b_lo got %h want e", lo); else n_pass++;
    n_total++; if (hi !== 32'd2) $display("FAIL b2b_hi got %h want 2", hi); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_multu;
    test_mult_signed;
    test_divide;
    test_div_by_zero;
    test_mf_stall;
    test_mt;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
